// File: rtl/traffic_pkg.sv
// Shared light-code, lamp-state and fault-code definitions for the lamp driver
// and the traffic controller that feeds it.
package traffic_pkg;

  typedef enum logic [1:0] {
    CODE_OFF    = 2'b00,
    CODE_RED    = 2'b01,
    CODE_GREEN  = 2'b10,
    CODE_YELLOW = 2'b11
  } light_code_e;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_RED,
    ST_GREEN,
    ST_YELLOW,
    ST_FLASH
  } lamp_state_e;

  typedef enum logic [1:0] {
    FAULT_NONE    = 2'b00,
    FAULT_ILLEGAL = 2'b01,
    FAULT_DWELL   = 2'b10
  } fault_code_e;

  localparam int unsigned DWELL_W = 8;

  function automatic lamp_state_e code_to_state(input logic [1:0] code);
    case (code)
      CODE_RED:    return ST_RED;
      CODE_GREEN:  return ST_GREEN;
      CODE_YELLOW: return ST_YELLOW;
      default:     return ST_OFF;
    endcase
  endfunction

  function automatic logic is_lit(input lamp_state_e s);
    return (s == ST_RED) || (s == ST_GREEN) || (s == ST_YELLOW);
  endfunction

  // Dropping to OFF is always allowed; otherwise only the normal cycle is legal.
  function automatic logic is_legal(input lamp_state_e from, input lamp_state_e to);
    return (to == ST_OFF)
        || (from == ST_OFF    && to == ST_RED)
        || (from == ST_RED    && to == ST_GREEN)
        || (from == ST_GREEN  && to == ST_YELLOW)
        || (from == ST_YELLOW && to == ST_RED);
  endfunction

endpackage

// File: rtl/lamp_driver_if.sv
// Controller-to-lamp-driver bundle: light code and fault release in,
// lamp, pedestrian and fault indications out.
interface lamp_driver_if;
  logic [1:0] light_code;
  logic       clear_fault;
  logic       lamp_red;
  logic       lamp_yellow;
  logic       lamp_green;
  logic       walk;
  logic       dont_walk;
  logic       fault;
  logic [1:0] fault_code;

  modport master (
    output light_code, clear_fault,
    input  lamp_red, lamp_yellow, lamp_green, walk, dont_walk, fault, fault_code
  );

  modport slave (
    input  light_code, clear_fault,
    output lamp_red, lamp_yellow, lamp_green, walk, dont_walk, fault, fault_code
  );
endinterface

// File: rtl/code_sync_filter.sv
// Two-flop synchronizer for the asynchronous light code plus a one-stage
// stability filter: a code is accepted only once it has been seen twice in a row.
module code_sync_filter (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] light_code,
  output logic [1:0] accepted_code,
  output logic       accepted_valid
);

  logic [1:0] s1, s2, s3;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= light_code;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign accepted_code  = s2;
  assign accepted_valid = (s2 == s3);

endmodule

// File: rtl/lamp_driver.sv
// Traffic lamp driver: filtered light code -> lamp state with illegal-transition
// and stuck-lamp supervision. Dwell check is built only with LAMP_DRIVER_DWELL_CHECK_EN.
module lamp_driver
  import traffic_pkg::*;
#(
  parameter int unsigned MAX_DWELL = 15
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          tick,
  lamp_driver_if.slave  bus
);

  if (MAX_DWELL > 255) begin : g_dwell_range
    $error("MAX_DWELL must fit the 8-bit dwell counter");
  end

  logic [1:0]  accepted_code;
  logic        accepted_valid;
  lamp_state_e state_q, state_d, target;
  logic        fault_q, fault_d;
  fault_code_e fault_code_q, fault_code_d;
  logic        flash_q, flash_d;
  logic        walk;

  code_sync_filter u_sync (
    .clk            (clk),
    .reset_n        (reset_n),
    .light_code     (bus.light_code),
    .accepted_code  (accepted_code),
    .accepted_valid (accepted_valid)
  );

`ifdef LAMP_DRIVER_DWELL_CHECK_EN
  localparam logic [DWELL_W-1:0] DWELL_LIMIT = DWELL_W'(MAX_DWELL);
  logic [DWELL_W-1:0] dwell_q, dwell_d;

  // A state change in the same cycle as a tick takes priority and zeroes the count.
  always_comb begin
    dwell_d = dwell_q;
    if (state_d != state_q)
      dwell_d = '0;
    else if (tick && is_lit(state_q))
      dwell_d = dwell_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) dwell_q <= '0;
    else          dwell_q <= dwell_d;
  end
`endif

  always_comb begin
    target       = code_to_state(accepted_code);
    state_d      = state_q;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    flash_d      = (state_q == ST_FLASH) ? (flash_q ^ tick) : 1'b0;

    if (state_q == ST_FLASH) begin
      if (bus.clear_fault && accepted_valid && target == ST_OFF) begin
        state_d      = ST_OFF;
        fault_d      = 1'b0;
        fault_code_d = FAULT_NONE;
      end
    end else if (accepted_valid && target != state_q) begin
      if (is_legal(state_q, target)) begin
        state_d = target;
      end else begin
        state_d      = ST_FLASH;
        fault_d      = 1'b1;
        fault_code_d = FAULT_ILLEGAL;
      end
    end
`ifdef LAMP_DRIVER_DWELL_CHECK_EN
    else if (tick && is_lit(state_q) && dwell_q == DWELL_LIMIT) begin
      state_d      = ST_FLASH;
      fault_d      = 1'b1;
      fault_code_d = FAULT_DWELL;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_OFF;
      fault_q      <= 1'b0;
      fault_code_q <= FAULT_NONE;
      flash_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
      flash_q      <= flash_d;
    end
  end

  assign walk            = (state_q == ST_RED);
  assign bus.walk        = walk;
  assign bus.dont_walk   = ~walk;
  assign bus.lamp_red    = (state_q == ST_RED);
  assign bus.lamp_green  = (state_q == ST_GREEN);
  assign bus.lamp_yellow = (state_q == ST_YELLOW) || (state_q == ST_FLASH && flash_q);
  assign bus.fault       = fault_q;
  assign bus.fault_code  = fault_code_q;

endmodule

// File: tb/tb_lamp_driver.sv
// Bench for lamp_driver: directed vector table and corner sequences, then random
// stimulus checked every cycle against a rule-level reference model.
module tb_lamp_driver;

`ifdef LAMP_DRIVER_DWELL_CHECK_EN
  localparam bit DWELL_EN = 1'b1;
`else
  localparam bit DWELL_EN = 1'b0;
`endif
  localparam int MAXD = 15;
  localparam int FL   = 4;

  // Packed output view: {red, yellow, green, walk, dont_walk, fault, fault_code}
  localparam logic [7:0] O_OFF    = 8'b000_01_0_00;
  localparam logic [7:0] O_RED    = 8'b100_10_0_00;
  localparam logic [7:0] O_GREEN  = 8'b001_01_0_00;
  localparam logic [7:0] O_YELLOW = 8'b010_01_0_00;
  localparam logic [7:0] O_FL_ILL = 8'b000_01_1_01;
  localparam logic [7:0] O_FL_DWL = 8'b000_01_1_10;

  logic clk = 1'b0;
  logic reset_n;
  logic tick;
  int   tests = 0;
  int   fails = 0;

  lamp_driver_if bus ();

  lamp_driver #(.MAX_DWELL(MAXD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference model: states 0..3 are the light codes themselves, 4 is flashing.
  int m_state, m_dwell, m_fc;
  bit m_flash, m_fault;
  int h[3];

  function automatic bit legal(input int from, input int to);
    return (to == 0) || (from == 0 && to == 1) || (from == 1 && to == 2)
        || (from == 2 && to == 3) || (from == 3 && to == 1);
  endfunction

  function automatic logic [1:0] legal_next(input int s);
    case (s)
      0: return 2'd1;
      1: return 2'd2;
      2: return 2'd3;
      3: return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  task automatic model_step(input logic [1:0] code, input logic tk, input logic clr,
                            input logic rst);
    int prev;
    int acc;
    bit acc_ok;
    if (rst) begin
      m_state = 0; m_dwell = 0; m_flash = 0; m_fault = 0; m_fc = 0;
      h[0] = 0; h[1] = 0; h[2] = 0;
      return;
    end
    // The code seen two and three sampling edges ago must agree to be accepted.
    acc_ok = (h[1] == h[2]);
    acc    = h[1];
    prev   = m_state;
    if (m_state == FL) begin
      if (clr && acc_ok && acc == 0) begin
        m_state = 0; m_fault = 0; m_fc = 0;
      end
    end else if (acc_ok && acc != m_state) begin
      if (legal(m_state, acc)) m_state = acc;
      else begin m_state = FL; m_fault = 1; m_fc = 1; end
    end else if (DWELL_EN && tk && m_state >= 1 && m_state <= 3 && m_dwell == MAXD) begin
      m_state = FL; m_fault = 1; m_fc = 2;
    end
    m_flash = (prev == FL) ? (m_flash ^ tk) : 1'b0;
    if (m_state != prev) m_dwell = 0;
    else if (tk && prev >= 1 && prev <= 3) m_dwell = m_dwell + 1;
    h[2] = h[1]; h[1] = h[0]; h[0] = int'(code);
  endtask

  function automatic logic [7:0] model_vec();
    logic [4:0] l;
    case (m_state)
      1:       l = 5'b100_10;
      2:       l = 5'b001_01;
      3:       l = 5'b010_01;
      FL:      l = {1'b0, m_flash, 3'b001};
      default: l = 5'b000_01;
    endcase
    return {l, m_fault, 2'(m_fc)};
  endfunction

  function automatic logic [7:0] dut_vec();
    return {bus.lamp_red, bus.lamp_yellow, bus.lamp_green, bus.walk, bus.dont_walk,
            bus.fault, bus.fault_code};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic [1:0] code, input logic tk, input logic clr,
                       input logic rst);
    bus.light_code  = code;
    bus.clear_fault = clr;
    tick            = tk;
    reset_n         = ~rst;
    @(posedge clk);
    model_step(code, tk, clr, rst);
    @(negedge clk);
    chk("model", dut_vec(), model_vec());
  endtask

  task automatic do_reset();
    cycle(2'd0, 1'b0, 1'b0, 1'b1);
    cycle(2'd0, 1'b0, 1'b0, 1'b1);
  endtask

  // Holds a code until it reaches the lamps (first sampling edge + 3 clk).
  task automatic go(input logic [1:0] code);
    for (int i = 0; i < 4; i++) cycle(code, 1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic [1:0] code;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[4];

  initial begin
    logic [7:0] prev_exp;
    logic [7:0] fl_exp;
    logic [1:0] code;
    int hold_left;
    int r;

    tbl[0] = '{code: 2'b01, exp: O_RED};
    tbl[1] = '{code: 2'b10, exp: O_GREEN};
    tbl[2] = '{code: 2'b11, exp: O_YELLOW};
    tbl[3] = '{code: 2'b01, exp: O_RED};

    bus.light_code  = 2'b00;
    bus.clear_fault = 1'b0;
    tick            = 1'b0;
    reset_n         = 1'b0;

    do_reset();
    chk("reset_state", dut_vec(), O_OFF);

    // Normal cycle: each code reaches the lamps 3 clk after it is first sampled.
    prev_exp = O_OFF;
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 3; c++) begin
        cycle(tbl[i].code, 1'b0, 1'b0, 1'b0);
        chk("latency_hold", dut_vec(), prev_exp);
      end
      cycle(tbl[i].code, 1'b0, 1'b0, 1'b0);
      chk("latency_edge", dut_vec(), tbl[i].exp);
      for (int t = 0; t < 20; t++) cycle(tbl[i].code, (t % 4) == 3, 1'b0, 1'b0);
      chk("hold_5_ticks", dut_vec(), tbl[i].exp);
      prev_exp = tbl[i].exp;
    end

    // One-clk green glitch during red is filtered out.
    cycle(2'b10, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 6; c++) begin
      cycle(2'b01, 1'b0, 1'b0, 1'b0);
      chk("glitch_ignored", dut_vec(), O_RED);
    end

    // GREEN -> RED is illegal: flash with fault 01, yellow toggling per tick.
    go(2'b10);
    chk("green_before_fault", dut_vec(), O_GREEN);
    go(2'b01);
    chk("illegal_flash", dut_vec(), O_FL_ILL);
    for (int k = 1; k <= 4; k++) begin
      cycle(2'b01, 1'b1, 1'b0, 1'b0);
      fl_exp = O_FL_ILL;
      fl_exp[6] = (k % 2) == 1;
      chk("flash_toggle", dut_vec(), fl_exp);
      cycle(2'b10, 1'b0, 1'b0, 1'b0);
      chk("flash_ignores_code", dut_vec(), fl_exp);
    end

    // Fault release needs clear_fault together with an accepted OFF code.
    for (int c = 0; c < 8; c++) cycle(2'b11, c % 2 == 1, 1'b1, 1'b0);
    chk("clear_with_yellow_code", dut_vec() & 8'b1011_1111, O_FL_ILL);
    for (int c = 0; c < 3; c++) begin
      cycle(2'b00, 1'b0, 1'b1, 1'b0);
      chk("clear_pending", dut_vec() & 8'b1011_1111, O_FL_ILL);
    end
    cycle(2'b00, 1'b0, 1'b1, 1'b0);
    chk("clear_to_off", dut_vec(), O_OFF);

    // Stuck red: the 16th tick in one lit state trips the dwell fault.
    do_reset();
    go(2'b01);
    for (int k = 1; k <= 16; k++) begin
      cycle(2'b01, 1'b1, 1'b0, 1'b0);
      if (k == 15) chk("dwell_tick15", dut_vec(), O_RED);
      if (k == 16) chk("dwell_tick16", dut_vec(), DWELL_EN ? O_FL_DWL : O_RED);
      cycle(2'b01, 1'b0, 1'b0, 1'b0);
    end

    // Reset during yellow with a simultaneous tick wins.
    do_reset();
    go(2'b01);
    go(2'b10);
    go(2'b11);
    chk("yellow_before_reset", dut_vec(), O_YELLOW);
    cycle(2'b11, 1'b1, 1'b0, 1'b1);
    chk("reset_in_yellow", dut_vec(), O_OFF);

    // Random traffic against the model.
    do_reset();
    hold_left = 0;
    code = 2'b00;
    for (int n = 0; n < 4000; n++) begin
      if (hold_left == 0) begin
        if ($urandom_range(0, 1) == 1) code = legal_next(m_state);
        else code = 2'($urandom_range(0, 3));
        r = int'($urandom_range(0, 9));
        if (r == 0) hold_left = 1;
        else if (r == 1) hold_left = int'($urandom_range(40, 90));
        else hold_left = int'($urandom_range(2, 12));
      end
      hold_left--;
      cycle(code, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 499) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
